sensor_round_robin_arbiter: RTL and testbench

SENSOR_ROUND_ROBIN_ARBITER -- requirements
Module: sensor_round_robin_arbiter

---
 rtl/sensor_arb_pkg.sv | 31 +++
 rtl/input_debouncer.sv | 48 ++++
 rtl/sensor_round_robin_arbiter.sv | 107 ++++++++++
 tb/tb_sensor_round_robin_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_arb_pkg.sv
// rtl/sensor_arb_pkg.sv - shared types, constants and channel search for the sensor arbiter
package sensor_arb_pkg;

    localparam int NUM_CHANNELS = 4;
    localparam int CH_W         = $clog2(NUM_CHANNELS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // First requesting channel strictly after last, wrapping; last itself is checked last.
    function automatic logic [CH_W-1:0] next_channel(
        input logic [NUM_CHANNELS-1:0] req,
        input logic [CH_W-1:0]         last
    );
        logic [CH_W-1:0] idx;
        logic            found;
        next_channel = last;
        found        = 1'b0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            idx = last + CH_W'(i);
            if (!found && req[idx]) begin
                next_channel = idx;
                found        = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchronizer and debounce for one active-low sensor input
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic clean_req
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int                LAST_INT = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LAST_INT);

    logic             sync_a;
    logic             sync_b;
    logic             raw_req;
    logic [CNT_W-1:0] cnt;

    assign raw_req = ~sync_b;

    // Flops reset high so an idle (unpressed) sensor reads as no request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
        end
    end

    // The counter stops at CNT_LAST, where the change is accepted, so it can never wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            clean_req <= 1'b0;
        end else if (raw_req == clean_req) begin
            cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
            clean_req <= raw_req;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_round_robin_arbiter.sv
// rtl/sensor_round_robin_arbiter.sv - four-channel round-robin sensor arbiter with timed grants
module sensor_round_robin_arbiter
    import sensor_arb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DWELL_CYCLES    = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic JA0,
    input  logic JA1,
    input  logic JA2,
    input  logic JA3,
    output logic LED0,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic busy
);

    localparam int                  DWELL_W    = $clog2(DWELL_CYCLES) + 1;
    localparam int                  DWELL_LAST = (DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0;
    localparam logic [DWELL_W-1:0]  DWELL_LOAD = DWELL_W'(DWELL_LAST);

    logic [NUM_CHANNELS-1:0] pins;
    logic [NUM_CHANNELS-1:0] clean_req;
    logic [NUM_CHANNELS-1:0] led;
    logic [NUM_CHANNELS-1:0] led_next;
    arb_state_t              state;
    arb_state_t              state_next;
    logic [CH_W-1:0]         last_grant;
    logic [CH_W-1:0]         last_next;
    logic [CH_W-1:0]         pick;
    logic [DWELL_W-1:0]      dwell;
    logic [DWELL_W-1:0]      dwell_next;
    logic                    busy_next;

    assign pins = {JA3, JA2, JA1, JA0};

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk      (clk),
            .reset    (reset),
            .pin      (pins[g]),
            .clean_req(clean_req[g])
        );
    end

    // last_grant starts at the top channel so channel 0 wins first after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= CH_W'(NUM_CHANNELS - 1);
            dwell      <= '0;
            led        <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_next;
            dwell      <= dwell_next;
            led        <= led_next;
            busy       <= busy_next;
        end
    end

    // Outputs are computed for the coming state so the registers line up with it.
    always_comb begin
        state_next = state;
        last_next  = last_grant;
        dwell_next = dwell;
        led_next   = '0;
        busy_next  = 1'b0;
        pick       = last_grant;
        case (state)
            IDLE: begin
                if (|clean_req) begin
                    pick       = next_channel(clean_req, last_grant);
                    last_next  = pick;
                    dwell_next = DWELL_LOAD;
                    led_next   = NUM_CHANNELS'(1) << pick;
                    busy_next  = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                busy_next = 1'b1;
                if (dwell == '0) begin
                    state_next = GAP;
                end else begin
                    dwell_next = dwell - 1'b1;
                    led_next   = led;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign {LED3, LED2, LED1, LED0} = led;

endmodule

// File: tb/tb_sensor_round_robin_arbiter.sv
// tb/tb_sensor_round_robin_arbiter.sv - scoreboard bench for the sensor round-robin arbiter
module tb_sensor_round_robin_arbiter;

    localparam int DEB   = 4;
    localparam int DWELL = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic JA0 = 1'b1, JA1 = 1'b1, JA2 = 1'b1, JA3 = 1'b1;
    logic LED0, LED1, LED2, LED3, busy;
    logic [3:0] led_bus;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        int ch;
        int dur;
    } grant_t;

    grant_t exp_q[$];

    assign led_bus = {LED3, LED2, LED1, LED0};

    always #5 clk = ~clk;

    sensor_round_robin_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .DWELL_CYCLES   (DWELL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .JA0  (JA0),
        .JA1  (JA1),
        .JA2  (JA2),
        .JA3  (JA3),
        .LED0 (LED0),
        .LED1 (LED1),
        .LED2 (LED2),
        .LED3 (LED3),
        .busy (busy)
    );

    task automatic set_ja(input logic [3:0] v);
        {JA3, JA2, JA1, JA0} = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_ja(4'hF);
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Each grant: one-hot LED for its dwell, a GAP cycle (busy high), then an IDLE cycle.
    task automatic observe_grants(input int n);
        int         waited;
        int         dur;
        logic [3:0] seen;
        logic [3:0] exp_led;
        grant_t     e;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (led_bus == 4'b0 && waited < 60) begin
                @(negedge clk);
                waited++;
            end
            if (led_bus == 4'b0) begin
                total++;
                $display("FAIL grant_timeout: no LED after %0d cycles, required grant %0d", waited, k);
                return;
            end
            if (k > 0) begin
                total++;
                if (waited !== 0) $display("FAIL back_to_back: extra idle cycles %0d, required 0", waited);
                else passed++;
            end
            seen = led_bus;
            dur  = 0;
            while (led_bus == seen && dur < 100) begin
                dur++;
                @(negedge clk);
            end
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_underflow: got LED %b, required no grant", seen);
                return;
            end
            passed++;
            e       = exp_q.pop_front();
            exp_led = 4'(1 << e.ch);
            total++;
            if (seen !== exp_led) $display("FAIL grant_channel: got %b, required %b", seen, exp_led);
            else passed++;
            total++;
            if (dur !== e.dur) $display("FAIL grant_dwell: got %0d, required %0d", dur, e.dur);
            else passed++;
            total++;
            if ({led_bus, busy} !== 5'b0000_1) $display("FAIL gap_cycle: got led=%b busy=%b, required led=0000 busy=1", led_bus, busy);
            else passed++;
            @(negedge clk);
            total++;
            if ({led_bus, busy} !== 5'b0000_0) $display("FAIL idle_cycle: got led=%b busy=%b, required led=0000 busy=0", led_bus, busy);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic bad;
        @(negedge clk);
        total++;
        if ({led_bus, busy} !== 5'b0) $display("FAIL reset_state: got led=%b busy=%b, required 0", led_bus, busy);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (led_bus !== 4'b0 || busy !== 1'b0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL reset_release_idle: activity with no requests, required none");
        else passed++;
    endtask

    task automatic test_glitch();
        logic bad;
        do_reset();
        set_ja(4'b1110);
        repeat (3) @(negedge clk);
        set_ja(4'hF);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (led_bus !== 4'b0 || busy !== 1'b0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL short_pulse: got led/busy activity, required none");
        else passed++;
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        set_ja(4'b1011);
        exp_q.push_back('{ch: 2, dur: DWELL});
        exp_q.push_back('{ch: 2, dur: DWELL});
        lat = 0;
        while (led_bus == 4'b0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 2 + DEB + 1) $display("FAIL grant_latency: got %0d, required %0d", lat, 2 + DEB + 1);
        else passed++;
        observe_grants(2);
    endtask

    task automatic test_all_channels();
        do_reset();
        for (int c = 0; c < 5; c++) exp_q.push_back('{ch: c % 4, dur: DWELL});
        set_ja(4'b0000);
        observe_grants(5);
    endtask

    task automatic test_reset_mid_grant();
        int waited;
        do_reset();
        set_ja(4'b1101);
        waited = 0;
        while (led_bus == 4'b0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (led_bus !== 4'b0010) $display("FAIL mid_first_grant: got %b, required 0010", led_bus);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (led_bus !== 4'b0010) $display("FAIL mid_fourth_cycle: got %b, required 0010", led_bus);
        else passed++;
        set_ja(4'b1100);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({led_bus, busy} !== 5'b0) $display("FAIL async_reset: got led=%b busy=%b, required 0", led_bus, busy);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('{ch: 0, dur: DWELL});
        observe_grants(1);
    endtask

    task automatic test_release_mid_grant();
        int         waited;
        int         dur;
        logic       bad;
        grant_t     e;
        logic [3:0] exp_led;
        do_reset();
        exp_q.push_back('{ch: 3, dur: DWELL});
        set_ja(4'b0111);
        waited = 0;
        while (led_bus == 4'b0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        dur = 1;
        @(negedge clk);
        set_ja(4'hF);
        while (led_bus == 4'b1000 && dur < 100) begin
            dur++;
            @(negedge clk);
        end
        e       = exp_q.pop_front();
        exp_led = 4'(1 << e.ch);
        total++;
        if (waited == 0 || exp_led !== 4'b1000) $display("FAIL release_channel: required LED %b after wait %0d", exp_led, waited);
        else passed++;
        total++;
        if (dur !== e.dur) $display("FAIL release_dwell: got %0d, required %0d", dur, e.dur);
        else passed++;
        total++;
        if ({led_bus, busy} !== 5'b0000_1) $display("FAIL release_gap: got led=%b busy=%b, required led=0000 busy=1", led_bus, busy);
        else passed++;
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (led_bus !== 4'b0 || busy !== 1'b0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL release_idle: activity after release, required idle with busy=0");
        else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_all_channels();
        test_reset_mid_grant();
        test_release_mid_grant();
        total++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
